pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives the write-enable, flush and bubble controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It detects load-use hazards and taken branches, and freezes the pipeline while a multi-cycle data-memory access is outstanding. A watchdog traps a memory access that never completes.

Parameters:
MEM_WAIT_MAX, 8, cycles in MEM_WAIT without mem_ready before entering ERR (must be >=1)
STALL_CNT_W, 16, width of the stall performance counter

Ports:
clk  input  1  pipeline clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
id_rs  input  5  rs field of the instruction in ID
id_rt  input  5  rt field of the instruction in ID
ex_memread  input  1  instruction in EX is a load
ex_rt  input  5  destination register of the load in EX
mem_req  input  1  instruction in MEM accesses data memory
mem_ready  input  1  data memory completes the access this cycle
ex_branch_taken  input  1  branch in EX resolved as taken
pc_write  output  1  PC load enable
ifid_write  output  1  IF/ID load enable
ifid_flush  output  1  IF/ID clears to NOP on the next edge
idex_write  output  1  ID/EX load enable
idex_flush  output  1  ID/EX control bits clear to 0 on the next edge
exmem_write  output  1  EX/MEM load enable
memwb_bubble  output  1  MEM/WB captures RegWrite=0 and MemtoReg=0 this cycle
mem_timeout  output  1  sticky error flag
stall_count  output  STALL_CNT_W  cycles with pc_write=0 (optional)

Behaviour:
- States: RUN, MEM_WAIT, ERR. Encoding is free. Reset goes to RUN.
- Reset: on the clk edge where rst=1, the state goes to RUN, wait_cnt to 0, mem_timeout to 0 and stall_count to 0.
- While rst=1, outputs are forced combinationally to: pc_write=0, ifid_write=0, idex_write=0, exmem_write=0, ifid_flush=1, idex_flush=1, memwb_bubble=1.
- Outputs are combinational from state and inputs (Mealy). This gives zero-latency stalls.
- Defaults in RUN with no hazard: all write enables 1, all flushes 0, memwb_bubble=0.
- Priority in RUN, highest first: memory wait > taken branch > load-use.
- Memory wait, RUN with mem_req=1 and mem_ready=0:
  - pc_write, ifid_write, idex_write and exmem_write all 0.
  - memwb_bubble=1, flushes 0.
  - Next state is MEM_WAIT with wait_cnt=1.
- Taken branch, RUN with ex_branch_taken=1 and no memory wait:
  - pc_write=1, ifid_flush=1, idex_flush=1.
  - A simultaneous load-use is ignored because the dependent instruction is squashed.
- Load-use, RUN with ex_memread=1, ex_rt!=0 and (ex_rt==id_rs or ex_rt==id_rt), and no higher-priority event:
  - pc_write=0, ifid_write=0, idex_flush=1.
  - idex_write=1 and exmem_write=1, so exactly one bubble is inserted.
- MEM_WAIT:
  - If mem_ready=0: same outputs as the memory-wait case; wait_cnt increments.
  - If mem_ready=0 and wait_cnt==MEM_WAIT_MAX: next state is ERR.
  - If mem_ready=1: normal RUN outputs (branch and load-use rules apply this cycle); next state RUN; wait_cnt cleared.
- ERR:
  - All write enables 0, memwb_bubble=1, flushes 0, mem_timeout=1.
  - Only rst exits ERR.
- wait_cnt is wide enough to hold MEM_WAIT_MAX and never wraps.
- mem_req/mem_ready are sampled only in RUN and MEM_WAIT.
- mem_ready=1 with mem_req=0 in RUN is ignored.
- Reset asserted mid-MEM_WAIT aborts the wait. The stalled pipeline contents are not replayed.

Optional Feature:
STALL_CNT_EN:
- Defined: stall_count is a saturating counter that increments on every non-reset edge where pc_write=0, including ERR cycles. It holds at all-ones.
- Undefined: stall_count is tied to 0 and no counter flops exist. All other behaviour is identical.

Test Plan:
- rst=1 for 2 cycles, then 0, with idle inputs -> during reset pc_write=0 and ifid_flush=1; after release all write enables=1, flushes=0, mem_timeout=0, stall_count=0.
- ex_memread=1, ex_rt=5, id_rs=5 for 1 cycle -> pc_write=0, ifid_write=0, idex_flush=1 for exactly 1 cycle. Repeat with ex_rt=0 -> no stall.
- ex_branch_taken=1 together with a load-use match -> ifid_flush=1, idex_flush=1, pc_write=1, no load-use stall.
- mem_req=1, mem_ready low for 3 cycles then high -> 3 cycles of all enables=0 and memwb_bubble=1, then advance on the 4th cycle; stall_count=3 with STALL_CNT_EN.
- mem_req=1, mem_ready held 0, MEM_WAIT_MAX=8 -> enters ERR after the 9th stalled cycle; mem_timeout=1 persists; rst clears it to 0.
- rst pulsed in the 2nd MEM_WAIT cycle -> next cycle in RUN with mem_timeout=0 and wait_cnt=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage MIPS pipeline.
// Drives PC / IF/ID / ID/EX / EX/MEM write enables, the IF/ID and ID/EX
// flushes and the MEM/WB bubble. Handles load-use, taken branches and
// multi-cycle data-memory waits, with a watchdog that traps into ERR.
// Optional macro STALL_CNT_EN: enables the saturating stall_count counter;
// without it stall_count is tied to zero.
module pipeline_hazard_ctrl #(
  parameter int MEM_WAIT_MAX = 8,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   ex_memread,
  input  logic [4:0]             ex_rt,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  input  logic                   ex_branch_taken,
  output logic                   pc_write,
  output logic                   ifid_write,
  output logic                   ifid_flush,
  output logic                   idex_write,
  output logic                   idex_flush,
  output logic                   exmem_write,
  output logic                   memwb_bubble,
  output logic                   mem_timeout,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam int WCW = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MEM_WAIT_MAX);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  state_t         state;
  logic [WCW-1:0] wait_cnt;
  logic           load_use;
  logic           mem_stall;

  assign load_use  = ex_memread && (ex_rt != 5'd0) &&
                     ((ex_rt == id_rs) || (ex_rt == id_rt));
  // In MEM_WAIT only mem_ready matters; the access is already in flight.
  assign mem_stall = ((state == RUN) && mem_req && !mem_ready) ||
                     ((state == MEM_WAIT) && !mem_ready);

  assign mem_timeout = (state == ERR);

  // Mealy output decode: reset > ERR > memory wait > branch > load-use.
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    if (rst) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
    end else if (state == ERR || mem_stall) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      // Squashes the dependent instruction, so any load-use is moot.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID, inject one bubble into ID/EX.
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // State machine and memory-wait watchdog counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_req && !mem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= WCW'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_MAX) begin
            state    <= ERR;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        ERR:     state <= ERR;
        default: state <= RUN;
      endcase
    end
  end

`ifdef STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  // Saturating count of cycles with the PC frozen (ERR cycles included).
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt_q <= '0;
    else if (!pc_write && (stall_cnt_q != '1))
      stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: directed stimulus, a behavioural
// model checked every cycle on the falling edge, plus literal expectations.
module tb_pipeline_hazard_ctrl;
  localparam int MAXW = 8;
  localparam int SCW  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic ex_memread = 0, mem_req = 0, mem_ready = 0, ex_branch_taken = 0;
  logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
  logic exmem_write, memwb_bubble, mem_timeout;
  logic [SCW-1:0] stall_count;

  pipeline_hazard_ctrl #(.MEM_WAIT_MAX(MAXW), .STALL_CNT_W(SCW)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .mem_req(mem_req),
    .mem_ready(mem_ready), .ex_branch_taken(ex_branch_taken),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_flush(idex_flush),
    .exmem_write(exmem_write), .memwb_bubble(memwb_bubble),
    .mem_timeout(mem_timeout), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit armed  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: trapped flag, consecutive memory-stall cycles, stall total.
  bit m_err = 0;
  int m_n   = 0;
  int m_cnt = 0;

  // Compare against the model each cycle, then advance it for the next edge.
  always @(negedge clk) begin
    if (armed) begin
      bit lu, ms;
      bit e_pc, e_ifw, e_idw, e_exw, e_iff, e_idf, e_bub;
      lu = ex_memread && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
      ms = !m_err && !mem_ready && (m_n > 0 || mem_req);
      {e_pc, e_ifw, e_idw, e_exw, e_iff, e_idf, e_bub} = 7'b1111_000;
      if (rst)                  {e_pc, e_ifw, e_idw, e_exw, e_iff, e_idf, e_bub} = 7'b0000_111;
      else if (m_err || ms)     {e_pc, e_ifw, e_idw, e_exw, e_iff, e_idf, e_bub} = 7'b0000_001;
      else if (ex_branch_taken) {e_iff, e_idf} = 2'b11;
      else if (lu)              {e_pc, e_ifw, e_idf} = 3'b001;
      chk("m_pc_write",     32'(pc_write),     32'(e_pc));
      chk("m_ifid_write",   32'(ifid_write),   32'(e_ifw));
      chk("m_idex_write",   32'(idex_write),   32'(e_idw));
      chk("m_exmem_write",  32'(exmem_write),  32'(e_exw));
      chk("m_ifid_flush",   32'(ifid_flush),   32'(e_iff));
      chk("m_idex_flush",   32'(idex_flush),   32'(e_idf));
      chk("m_memwb_bubble", 32'(memwb_bubble), 32'(e_bub));
      chk("m_mem_timeout",  32'(mem_timeout),  32'(m_err));
      chk("m_stall_count",  32'(stall_count),  32'(m_cnt));
      if (rst) begin
        m_err = 0; m_n = 0; m_cnt = 0;
      end else begin
`ifdef STALL_CNT_EN
        if (!e_pc && m_cnt < (1 << SCW) - 1) m_cnt++;
`endif
        if (!m_err) begin
          if (ms) begin
            m_n++;
            if (m_n > MAXW) m_err = 1;
          end else m_n = 0;
        end
      end
    end
  end

  task automatic idle();
    id_rs = 0; id_rt = 0; ex_rt = 0; ex_memread = 0;
    mem_req = 0; mem_ready = 0; ex_branch_taken = 0;
  endtask

  // Let combinational outputs settle, then run through one edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    int exp_sc;
    idle(); rst = 1;
    @(posedge clk); armed = 1; #1;
    // Reset: forced outputs for two cycles
    #1 chk("rst_pc_write", 32'(pc_write), 0);
    chk("rst_ifid_flush", 32'(ifid_flush), 1);
    step(); step();
    rst = 0; #1;
    chk("rel_enables", 32'({pc_write, ifid_write, idex_write, exmem_write}), 32'hF);
    chk("rel_flushes", 32'({ifid_flush, idex_flush, memwb_bubble}), 0);
    chk("rel_timeout", 32'(mem_timeout), 0);
    chk("rel_stall_count", 32'(stall_count), 0);
    step();

    // Load-use on rs: exactly one stall cycle
    ex_memread = 1; ex_rt = 5; id_rs = 5; #1;
    chk("lu_ctrl", 32'({pc_write, ifid_write, idex_flush, idex_write}), 32'b0011);
    step();
    idle(); #1 chk("lu_release", 32'(pc_write), 1);
    step();
    // Load into $zero never stalls
    ex_memread = 1; ex_rt = 0; id_rs = 0; #1;
    chk("lu_zero", 32'({pc_write, idex_flush}), 32'b10);
    step();
    // Load-use on rt
    idle(); ex_memread = 1; ex_rt = 9; id_rt = 9; #1;
    chk("lu_rt", 32'({pc_write, ifid_write}), 0);
    step();
    // Branch wins over load-use
    ex_branch_taken = 1; ex_memread = 1; ex_rt = 7; id_rs = 7; #1;
    chk("br_ctrl", 32'({pc_write, ifid_flush, idex_flush, ifid_write}), 32'hF);
    step();
    // mem_ready without mem_req is ignored
    idle(); mem_ready = 1; #1 chk("ready_noreq", 32'(pc_write), 1);
    step();

    // 3-cycle memory wait, then advance; counter restarted by reset
    idle(); rst = 1; step(); rst = 0;
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("mw_stall", 32'({pc_write, ifid_write, idex_write, exmem_write, memwb_bubble}), 32'b00001);
      step();
    end
    mem_ready = 1; #1;
    chk("mw_advance", 32'({pc_write, exmem_write, memwb_bubble}), 32'b110);
    step();
    idle(); #1;
`ifdef STALL_CNT_EN
    exp_sc = 3;
`else
    exp_sc = 0;
`endif
    chk("mw_stall_count", 32'(stall_count), 32'(exp_sc));
    step();

    // Watchdog: ninth stalled cycle traps into ERR
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 9; i++) begin
      #1 chk("wd_pre_timeout", 32'(mem_timeout), 0);
      step();
    end
    #1 chk("wd_timeout", 32'(mem_timeout), 1);
    mem_ready = 1; #1;
    chk("err_ignores_ready", 32'({pc_write, memwb_bubble, mem_timeout}), 32'b011);
    step(); idle(); step(); step();
    #1 chk("err_sticky", 32'(mem_timeout), 1);
    rst = 1; step(); rst = 0; #1;
    chk("err_rst_clear", 32'({mem_timeout, pc_write}), 32'b01);
    step();

    // Reset in the second wait cycle aborts the wait
    mem_req = 1; mem_ready = 0; step();
    rst = 1; #1 chk("abort_rst_forced", 32'(ifid_flush), 1);
    step(); rst = 0; idle(); #1;
    chk("abort_run", 32'({mem_timeout, pc_write}), 32'b01);
    step();
    // A fresh wait needs the full nine cycles again
    mem_req = 1;
    for (int i = 0; i < 8; i++) step();
    #1 chk("abort_cnt_cleared", 32'(mem_timeout), 0);
    step();
    #1 chk("abort_then_timeout", 32'(mem_timeout), 1);
    idle(); rst = 1; step(); rst = 0; step();

    armed = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
